kernel_invoker: RTL
===================

Name: kernel_invoker

Overview:
- Host-side counterpart of a generated dataflow kernel wrapper: drives the kernel's argument and start channels and collects its result and end channels.
- Accepts one invocation request (two 64-bit arguments), issues it to the kernel, waits for out0 and end, and returns a single response.
- Single outstanding invocation, cycle timeout watchdog and invocation counter.
- Sits between the system-side request/response stream and the kernel wrapper in integration and test harnesses.

Parameters:
- DATA_W, 64, width of arg0, arg1 and out0.
- TIMEOUT_CYCLES, 1024, maximum cycles in RUN before abort; 0 disables the watchdog.
- CNT_W, 32, width of invoc_count.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request ready
- req_arg0  in  DATA_W  first argument
- req_arg1  in  DATA_W  second argument
- k_arg0  out  DATA_W  kernel arg0 data
- k_arg0_valid  out  1  kernel arg0 valid
- k_arg0_ready  in  1  kernel arg0 ready
- k_arg1  out  DATA_W  kernel arg1 data
- k_arg1_valid  out  1  kernel arg1 valid
- k_arg1_ready  in  1  kernel arg1 ready
- k_start_valid  out  1  kernel start token valid
- k_start_ready  in  1  kernel start ready
- k_out0  in  DATA_W  kernel result
- k_out0_valid  in  1  kernel result valid
- k_out0_ready  out  1  kernel result ready
- k_end_valid  in  1  kernel end token valid
- k_end_ready  out  1  kernel end ready
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response ready
- rsp_data  out  DATA_W  captured out0, or 0 on timeout
- rsp_timeout  out  1  response is a timeout abort
- halted  out  1  sticky; set after a timeout response is accepted
- invoc_count  out  CNT_W  count of successfully completed responses

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: state=IDLE.
  - All valids, readies and rsp_* are 0, except req_ready=1 in IDLE after reset.
  - halted=0, invoc_count=0, done flags cleared, watchdog=0.
  - Reset during RUN or RESP abandons the invocation with no response.
- All handshakes complete on a cycle where valid&ready=1. Each valid is held with stable data until its handshake.
- States: IDLE, RUN, RESP, HALT.
- IDLE:
  - req_ready=1.
  - On req handshake: register the args into k_arg0/k_arg1, clear the five done flags (a0, a1, st, o, e), zero the watchdog, go to RUN.
  - Kernel valids rise the next cycle (1-cycle issue latency).
- RUN:
  - k_arg0_valid=!a0; k_arg1_valid=!a1; k_start_valid=!st.
  - k_out0_ready=!o; k_end_ready=!e.
  - Each channel is independent, like an eager fork/join. A handshake sets that channel's done flag; its valid/ready drops the next cycle.
  - out0 and end may arrive in any order, in the same cycle, or before all inputs are accepted.
  - The out0 handshake captures k_out0 into the result register.
  - Completion: all five flags set, counting this cycle's handshakes. Next state is RESP with rsp_timeout=0.
  - Watchdog: increments each RUN cycle. If TIMEOUT_CYCLES≠0, watchdog==TIMEOUT_CYCLES-1 and completion is not occurring, go to RESP with rsp_timeout=1 and rsp_data=0.
  - Completion wins over timeout in the same cycle.
- RESP:
  - rsp_valid=1; all kernel valids and readies are 0.
  - On rsp_ready with rsp_timeout=0: go to IDLE and increment invoc_count, wrapping modulo 2^CNT_W.
  - On rsp_ready with rsp_timeout=1: go to HALT.
- HALT:
  - halted=1; req_ready, rsp_valid and all kernel valids/readies are 0.
  - Only rst exits HALT.
- Minimum turnaround is 4 cycles request-to-response for a kernel that is ready every cycle and produces out0/end the cycle after start: req accept, RUN (issue), RUN (collect), RESP.
- No combinational path from any input to k_*_valid, req_ready or rsp_valid. Readies to the kernel depend only on registered state.

Test Plan:
- Ideal kernel (all readies=1, out0=0x0000_0000_0000_002A with end one cycle after start) → rsp_data=0x2A, rsp_timeout=0; invoc_count 0→1; 4-cycle turnaround.
- Staggered acceptance (k_arg0_ready at cycle 3, k_arg1_ready at cycle 1, k_start_ready at cycle 5) → each valid drops exactly one cycle after its own handshake; k_arg0/k_arg1 stable while valid.
- Result ordering:
  - end before out0 → both collected; rsp_data matches out0.
  - end and out0 in the same cycle → completion in that cycle.
  - out0 before start is accepted → captured and held.
- Back-pressure: rsp_ready low for 10 cycles → rsp_valid and rsp_data held; req_ready=0 throughout.
- Timeout with TIMEOUT_CYCLES=8, kernel never asserts end → rsp_valid with rsp_timeout=1 and rsp_data=0 after 8 RUN cycles; after accept, halted=1 and req_ready=0; rst clears halted. Completion exactly on cycle 8 → normal response.
- Reset mid-RUN (assert rst with the start token pending) → next cycle all kernel valids=0, req_ready=1, no response emitted, invoc_count unchanged at 0.

Source files
------------

// File: rtl/kernel_invoker.sv
// Host-side invoker for a dataflow kernel wrapper: issues one two-argument
// invocation, collects out0/end, and returns a single (possibly timed-out) response.
module kernel_invoker #(
  parameter int unsigned DATA_W         = 64,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_arg0,
  input  logic [DATA_W-1:0] req_arg1,
  output logic [DATA_W-1:0] k_arg0,
  output logic              k_arg0_valid,
  input  logic              k_arg0_ready,
  output logic [DATA_W-1:0] k_arg1,
  output logic              k_arg1_valid,
  input  logic              k_arg1_ready,
  output logic              k_start_valid,
  input  logic              k_start_ready,
  input  logic [DATA_W-1:0] k_out0,
  input  logic              k_out0_valid,
  output logic              k_out0_ready,
  input  logic              k_end_valid,
  output logic              k_end_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_timeout,
  output logic              halted,
  output logic [CNT_W-1:0]  invoc_count
);

  typedef enum logic [1:0] {IDLE, RUN, RESP, HALT} state_t;

  state_t            state;
  logic [DATA_W-1:0] result;
  logic [31:0]       watchdog;

  logic a0_done, a1_done, st_done, o_done, e_done;
  logic o_fire, complete, expire;

  // The per-channel valid/ready registers double as the inverted done flags,
  // so a channel counts as done if already finished or handshaking this cycle.
  always_comb begin
    a0_done  = !k_arg0_valid  || k_arg0_ready;
    a1_done  = !k_arg1_valid  || k_arg1_ready;
    st_done  = !k_start_valid || k_start_ready;
    o_done   = !k_out0_ready  || k_out0_valid;
    e_done   = !k_end_ready   || k_end_valid;
    o_fire   = k_out0_ready && k_out0_valid;
    complete = a0_done && a1_done && st_done && o_done && e_done;
    expire   = (TIMEOUT_CYCLES != 0) && (watchdog == TIMEOUT_CYCLES - 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      req_ready     <= 1'b1;
      k_arg0        <= '0;
      k_arg1        <= '0;
      k_arg0_valid  <= 1'b0;
      k_arg1_valid  <= 1'b0;
      k_start_valid <= 1'b0;
      k_out0_ready  <= 1'b0;
      k_end_ready   <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_timeout   <= 1'b0;
      halted        <= 1'b0;
      invoc_count   <= '0;
      result        <= '0;
      watchdog      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            k_arg0        <= req_arg0;
            k_arg1        <= req_arg1;
            k_arg0_valid  <= 1'b1;
            k_arg1_valid  <= 1'b1;
            k_start_valid <= 1'b1;
            k_out0_ready  <= 1'b1;
            k_end_ready   <= 1'b1;
            watchdog      <= '0;
            req_ready     <= 1'b0;
            state         <= RUN;
          end
        end
        RUN: begin
          watchdog <= watchdog + 32'd1;
          if (k_arg0_ready)  k_arg0_valid  <= 1'b0;
          if (k_arg1_ready)  k_arg1_valid  <= 1'b0;
          if (k_start_ready) k_start_valid <= 1'b0;
          if (k_out0_valid)  k_out0_ready  <= 1'b0;
          if (k_end_valid)   k_end_ready   <= 1'b0;
          if (o_fire) result <= k_out0;
          if (complete) begin
            rsp_valid   <= 1'b1;
            rsp_timeout <= 1'b0;
            rsp_data    <= o_fire ? k_out0 : result;
            state       <= RESP;
          end else if (expire) begin
            k_arg0_valid  <= 1'b0;
            k_arg1_valid  <= 1'b0;
            k_start_valid <= 1'b0;
            k_out0_ready  <= 1'b0;
            k_end_ready   <= 1'b0;
            rsp_valid     <= 1'b1;
            rsp_timeout   <= 1'b1;
            rsp_data      <= '0;
            state         <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            if (rsp_timeout) begin
              halted <= 1'b1;
              state  <= HALT;
            end else begin
              invoc_count <= invoc_count + 1'b1;
              req_ready   <= 1'b1;
              state       <= IDLE;
            end
          end
        end
        HALT: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
